rom_arbiter: RTL and testbench

- Shares the single combinational read port of the boot/program ROM (0xBFC00000-0xBFC00FFF, byte-addressed, little-endian 32-bit words) between two requesters: instruction fetch (IF) and data load (LD, for reading constant tables stored in ROM).
- Sits between the fetch stage, the memory stage and the ROM.
- Arbitrates with starvation protection, range- and alignment-checks each access, and registers the returned word so both requesters see a fixed 1-cycle read latency.

---
 rtl/rom_arbiter.sv | 112 +++++++++++
 tb/tb_rom_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// Two-requester arbiter for the boot/program ROM read port. Load wins on
// contention unless fetch has been starved; the returned word is registered.
module rom_arbiter #(
  parameter int                         ADDRESS_WIDTH = 32,
  parameter int                         DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDR     = 32'hBFC00000,
  parameter int                         ROM_BYTES     = 4096,
  parameter int                         STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     if_req,
  input  logic [ADDRESS_WIDTH-1:0] if_addr,
  output logic                     if_gnt,
  output logic                     if_rvalid,
  output logic [DATA_WIDTH-1:0]    if_rdata,
  output logic                     if_err,
  input  logic                     ld_req,
  input  logic [ADDRESS_WIDTH-1:0] ld_addr,
  output logic                     ld_gnt,
  output logic                     ld_rvalid,
  output logic [DATA_WIDTH-1:0]    ld_rdata,
  output logic                     ld_err,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_dout,
  output logic [3:0]               dbg_starve_cnt,
  output logic                     dbg_last_owner
);

  typedef enum logic {OWNER_IF = 1'b0, OWNER_LD = 1'b1} owner_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR =
    BASE_ADDR + ADDRESS_WIDTH'(ROM_BYTES - 4);

  // Handshake: a requester holds req with a stable address; gnt is issued
  // combinationally in the same cycle and rvalid follows exactly one cycle later.

  logic [3:0]            starve_q, starve_d;
  owner_t                last_owner_q, last_owner_d;
  logic                  if_rvalid_q, if_rvalid_d;
  logic                  if_err_q, if_err_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic                  ld_rvalid_q, ld_rvalid_d;
  logic                  ld_err_q, ld_err_d;
  logic [DATA_WIDTH-1:0] ld_rdata_q, ld_rdata_d;
  logic                  gnt_err;
  logic [DATA_WIDTH-1:0] gnt_word;

  always_comb begin
    if_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (rst_n) begin
      if (ld_req && (!if_req || (starve_q != LIMIT))) ld_gnt = 1'b1;
      else if (if_req)                                 if_gnt = 1'b1;
    end

    rom_addr = ld_gnt ? ld_addr : if_addr;
    gnt_err  = (rom_addr < BASE_ADDR) || (rom_addr > LAST_ADDR) ||
               (rom_addr[1:0] != 2'b00);
    gnt_word = gnt_err ? '0 : rom_dout;

    starve_d = starve_q;
    if (if_gnt || !if_req)              starve_d = '0;
    else if (ld_gnt && starve_q != LIMIT) starve_d = starve_q + 4'd1;

    last_owner_d = last_owner_q;
    if (if_gnt)      last_owner_d = OWNER_IF;
    else if (ld_gnt) last_owner_d = OWNER_LD;

    if_rvalid_d = if_gnt;
    if_err_d    = if_gnt & gnt_err;
    if_rdata_d  = if_gnt ? gnt_word : if_rdata_q;
    ld_rvalid_d = ld_gnt;
    ld_err_d    = ld_gnt & gnt_err;
    ld_rdata_d  = ld_gnt ? gnt_word : ld_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q     <= '0;
      last_owner_q <= OWNER_IF;
      if_rvalid_q  <= 1'b0;
      if_err_q     <= 1'b0;
      if_rdata_q   <= '0;
      ld_rvalid_q  <= 1'b0;
      ld_err_q     <= 1'b0;
      ld_rdata_q   <= '0;
    end else begin
      starve_q     <= starve_d;
      last_owner_q <= last_owner_d;
      if_rvalid_q  <= if_rvalid_d;
      if_err_q     <= if_err_d;
      if_rdata_q   <= if_rdata_d;
      ld_rvalid_q  <= ld_rvalid_d;
      ld_err_q     <= ld_err_d;
      ld_rdata_q   <= ld_rdata_d;
    end
  end

  assign if_rvalid      = if_rvalid_q;
  assign if_err         = if_err_q;
  assign if_rdata       = if_rdata_q;
  assign ld_rvalid      = ld_rvalid_q;
  assign ld_err         = ld_err_q;
  assign ld_rdata       = ld_rdata_q;
  assign dbg_starve_cnt = starve_q;
  assign dbg_last_owner = last_owner_q;

  a_one_grant: assert property (@(posedge clk) !(if_gnt && ld_gnt));

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: vector table for single accesses, plus
// contention, starvation and mid-stream reset sequences.
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, ld_req;
  logic [31:0] if_addr, ld_addr;
  logic        if_gnt, ld_gnt;
  logic        if_rvalid, ld_rvalid, if_err, ld_err;
  logic [31:0] if_rdata, ld_rdata, rom_addr, rom_dout;
  logic [3:0]  dbg_starve_cnt;
  logic        dbg_last_owner;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rom_dout = ~rom_addr;

  rom_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_err(ld_err),
    .rom_addr(rom_addr), .rom_dout(rom_dout),
    .dbg_starve_cnt(dbg_starve_cnt), .dbg_last_owner(dbg_last_owner)
  );

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic        e_if_gnt;
    logic        e_ld_gnt;
    logic [31:0] e_rom_addr;
    logic        e_if_rvalid;
    logic        e_if_err;
    logic [31:0] e_if_rdata;
    logic        e_ld_rvalid;
    logic        e_ld_err;
    logic [31:0] e_ld_rdata;
  } vec_t;

  vec_t vecs[13];
  logic [0:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic lr, input logic [31:0] la);
    @(negedge clk);
    if_req  = ir;
    if_addr = ia;
    ld_req  = lr;
    ld_addr = la;
    #1;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       own;
    logic [3:0] exp_starve;

    vecs[0]  = '{1'b1, 32'hBFC00010, 1'b0, 32'h0,         1'b1, 1'b0, 32'hBFC00010, 1'b1, 1'b0, 32'h403FFFEF, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h403FFFEF, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 32'h0,         1'b1, 32'hBFC01000, 1'b0, 1'b1, 32'hBFC01000, 1'b0, 1'b0, 32'h403FFFEF, 1'b1, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, 32'h0,         1'b1, 32'hBFC00020, 1'b0, 1'b1, 32'hBFC00020, 1'b0, 1'b0, 32'h403FFFEF, 1'b1, 1'b0, 32'h403FFFDF};
    vecs[4]  = '{1'b0, 32'h0,         1'b1, 32'hBFC00002, 1'b0, 1'b1, 32'hBFC00002, 1'b0, 1'b0, 32'h403FFFEF, 1'b1, 1'b1, 32'h0};
    vecs[5]  = '{1'b1, 32'hBFBFFFFC, 1'b0, 32'h0,         1'b1, 1'b0, 32'hBFBFFFFC, 1'b1, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 32'hBFC00FFC, 1'b0, 32'h0,         1'b1, 1'b0, 32'hBFC00FFC, 1'b1, 1'b0, 32'h403FF003, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'hBFC00FFC, 1'b1, 32'hBFC00FFC, 1'b0, 1'b1, 32'hBFC00FFC, 1'b0, 1'b0, 32'h403FF003, 1'b1, 1'b0, 32'h403FF003};
    vecs[8]  = '{1'b1, 32'hBFC00FFD, 1'b0, 32'h0,         1'b1, 1'b0, 32'hBFC00FFD, 1'b1, 1'b1, 32'h0,         1'b0, 1'b0, 32'h403FF003};
    vecs[9]  = '{1'b1, 32'hBFC00000, 1'b0, 32'h0,         1'b1, 1'b0, 32'hBFC00000, 1'b1, 1'b0, 32'h403FFFFF, 1'b0, 1'b0, 32'h403FF003};
    vecs[10] = '{1'b1, 32'hBFC00100, 1'b1, 32'hBFC00004, 1'b0, 1'b1, 32'hBFC00004, 1'b0, 1'b0, 32'h403FFFFF, 1'b1, 1'b0, 32'h403FFFFB};
    vecs[11] = '{1'b1, 32'hBFC00100, 1'b0, 32'h0,         1'b1, 1'b0, 32'hBFC00100, 1'b1, 1'b0, 32'h403FFEFF, 1'b0, 1'b0, 32'h403FFFFB};
    vecs[12] = '{1'b0, 32'h0,         1'b1, 32'hBFC01004, 1'b0, 1'b1, 32'hBFC01004, 1'b0, 1'b0, 32'h403FFEFF, 1'b1, 1'b1, 32'h0};

    // Clock/reset with a pending fetch: grants must stay low during reset.
    rst_n = 1'b0; if_req = 1'b1; if_addr = 32'hBFC00010; ld_req = 1'b1; ld_addr = 32'hBFC00020;
    repeat (3) after_edge();
    chk("rst_if_gnt", {31'b0, if_gnt}, 32'd0);
    chk("rst_ld_gnt", {31'b0, ld_gnt}, 32'd0);
    chk("rst_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    chk("rst_ld_rvalid", {31'b0, ld_rvalid}, 32'd0);
    chk("rst_if_err", {31'b0, if_err}, 32'd0);
    chk("rst_ld_err", {31'b0, ld_err}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_ld_rdata", ld_rdata, 32'd0);
    chk("rst_starve", {28'b0, dbg_starve_cnt}, 32'd0);
    chk("rst_last_owner", {31'b0, dbg_last_owner}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; if_req = 1'b0; ld_req = 1'b0;

    // Single-cycle vector table.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].if_req, vecs[i].if_addr, vecs[i].ld_req, vecs[i].ld_addr);
      chk($sformatf("v%0d_if_gnt", i), {31'b0, if_gnt}, {31'b0, vecs[i].e_if_gnt});
      chk($sformatf("v%0d_ld_gnt", i), {31'b0, ld_gnt}, {31'b0, vecs[i].e_ld_gnt});
      chk($sformatf("v%0d_rom_addr", i), rom_addr, vecs[i].e_rom_addr);
      after_edge();
      chk($sformatf("v%0d_if_rvalid", i), {31'b0, if_rvalid}, {31'b0, vecs[i].e_if_rvalid});
      chk($sformatf("v%0d_if_err", i), {31'b0, if_err}, {31'b0, vecs[i].e_if_err});
      chk($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].e_if_rdata);
      chk($sformatf("v%0d_ld_rvalid", i), {31'b0, ld_rvalid}, {31'b0, vecs[i].e_ld_rvalid});
      chk($sformatf("v%0d_ld_err", i), {31'b0, ld_err}, {31'b0, vecs[i].e_ld_err});
      chk($sformatf("v%0d_ld_rdata", i), ld_rdata, vecs[i].e_ld_rdata);
    end

    // Contention for 10 cycles: owner pattern 0=IF, 1=LD.
    exp_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_starve = 4'd0;
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 32'hBFC00200, 1'b1, 32'hBFC00300);
      own = exp_q.pop_front();
      chk($sformatf("c%0d_starve", c), {28'b0, dbg_starve_cnt}, {28'b0, exp_starve});
      chk($sformatf("c%0d_if_gnt", c), {31'b0, if_gnt}, {31'b0, ~own});
      chk($sformatf("c%0d_ld_gnt", c), {31'b0, ld_gnt}, {31'b0, own});
      after_edge();
      chk($sformatf("c%0d_if_rvalid", c), {31'b0, if_rvalid}, {31'b0, ~own});
      chk($sformatf("c%0d_ld_rvalid", c), {31'b0, ld_rvalid}, {31'b0, own});
      if (own) chk($sformatf("c%0d_ld_rdata", c), ld_rdata, 32'h403FFCFF);
      else     chk($sformatf("c%0d_if_rdata", c), if_rdata, 32'h403FFDFF);
      chk($sformatf("c%0d_last_owner", c), {31'b0, dbg_last_owner}, {31'b0, own});
      exp_starve = own ? exp_starve + 4'd1 : 4'd0;
    end

    // Continuous fetch, then reset for two edges mid-stream.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'hBFC00040 + 32'(4 * k), 1'b0, 32'h0);
      after_edge();
      chk($sformatf("s%0d_if_rvalid", k), {31'b0, if_rvalid}, 32'd1);
      chk($sformatf("s%0d_if_rdata", k), if_rdata, ~(32'hBFC00040 + 32'(4 * k)));
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr_if_gnt", {31'b0, if_gnt}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      after_edge();
      chk($sformatf("mr%0d_if_rvalid", k), {31'b0, if_rvalid}, 32'd0);
      chk($sformatf("mr%0d_starve", k), {28'b0, dbg_starve_cnt}, 32'd0);
      chk($sformatf("mr%0d_if_rdata", k), if_rdata, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1; if_req = 1'b1; if_addr = 32'hBFC00080; ld_req = 1'b1; ld_addr = 32'hBFC00090;
    #1;
    chk("post_rst_ld_gnt", {31'b0, ld_gnt}, 32'd1);
    chk("post_rst_if_gnt", {31'b0, if_gnt}, 32'd0);
    after_edge();
    chk("post_rst_ld_rvalid", {31'b0, ld_rvalid}, 32'd1);
    chk("post_rst_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    chk("post_rst_ld_rdata", ld_rdata, 32'h403FFF6F);
    chk("post_rst_starve", {28'b0, dbg_starve_cnt}, 32'd1);

    drive(1'b0, 32'h0, 1'b0, 32'h0);
    after_edge();
    chk("idle_ld_rvalid", {31'b0, ld_rvalid}, 32'd0);
    chk("idle_ld_rdata_hold", ld_rdata, 32'h403FFF6F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
